// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//
// Purpose: lets two requesters share one single-ported, byte-enabled data
// memory. Port 0 is the CPU MEM stage and port 1 is the DMA/debug loader.
// One transaction is in flight at a time. The block turns byte, half and word
// accesses into a word address, byte enables and lane-aligned write data. On
// a load it picks the addressed lane from the read data and sign- or
// zero-extends it. The SRAM returns read data one cycle after the read strobe.
//
// Build option: define DM_FIXED_PRIO_EN to make port 0 win every tie.
// Without it (the default), ties go round-robin.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pN_req_i / pN_gnt_o request valid / accepted this cycle (N = 0, 1)
//   pN_we_i             1 = store, 0 = load
//   pN_addr_i           byte address
//   pN_wdata_i          store data (low byte/half used for sb/sh)
//   pN_mode_i           [1:0] 00 word, 01 byte, 10 half, 11 reserved;
//                       [2] 1 = zero-extend load
//   pN_done_o           one-cycle completion pulse
//   pN_err_o            misaligned/reserved access, valid with done
//   pN_rdata_o          load result, held until the port's next done
//   mem_en_o, mem_we_o  SRAM strobe / write
//   mem_addr_o          SRAM word address
//   mem_be_o            byte enables, bit i covers bits [8i+7:8i]
//   mem_wdata_o         lane-aligned write data
//   mem_rdata_i         SRAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module dm_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req_i,
    output logic              p0_gnt_o,
    input  logic              p0_we_i,
    input  logic [31:0]       p0_addr_i,
    input  logic [31:0]       p0_wdata_i,
    input  logic [2:0]        p0_mode_i,
    output logic              p0_done_o,
    output logic              p0_err_o,
    output logic [31:0]       p0_rdata_o,

    input  logic              p1_req_i,
    output logic              p1_gnt_o,
    input  logic              p1_we_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_wdata_i,
    input  logic [2:0]        p1_mode_i,
    output logic              p1_done_o,
    output logic              p1_err_o,
    output logic [31:0]       p1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;

    localparam logic [1:0] M_WORD  = 2'b00;
    localparam logic [1:0] M_BYTE  = 2'b01;
    localparam logic [1:0] M_HALF  = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic              we_q;
    logic [2:0]        mode_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata0_q, rdata1_q;
    logic              rdata_en;

    logic              win;        // 0 = port 0, 1 = port 1
    logic              accept;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_mode;
    logic              sel_legal;

    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic              sext;
    logic [31:0]       load_val;

    // Only the word-index bits of the address reach the memory.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^sel_addr[31:ADDR_W+2];

    // ---------------------------------------------------------------- arbiter
`ifdef DM_FIXED_PRIO_EN
    assign win = ~p0_req_i;
`else
    logic last_grant_q;

    // On a tie the port that did not win last time goes first; a lone
    // requester always wins.
    assign win = (p0_req_i && p1_req_i) ? ~last_grant_q : ~p0_req_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;     // port 0 takes the first tie
        end else if (accept) begin
            last_grant_q <= win;
        end
    end
`endif

    // Grant is combinational and only offered while idle and out of reset.
    assign accept   = (state_q == S_IDLE) && !reset && (p0_req_i || p1_req_i);
    assign p0_gnt_o = accept && !win;
    assign p1_gnt_o = accept &&  win;

    assign sel_we    = win ? p1_we_i    : p0_we_i;
    assign sel_addr  = win ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = win ? p1_wdata_i : p0_wdata_i;
    assign sel_mode  = win ? p1_mode_i  : p0_mode_i;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        sel_legal = 1'b0;
        case (sel_mode[1:0])
            M_WORD:  sel_legal = (sel_addr[1:0] == 2'b00);
            M_BYTE:  sel_legal = 1'b1;
            M_HALF:  sel_legal = !sel_addr[0];
            default: sel_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d  = state_q;
        done_d   = 2'b00;
        err_d    = 2'b00;
        rdata_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sel_legal) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Illegal requests never touch memory; they finish
                        // with an error on the next cycle.
                        done_d[win] = 1'b1;
                        err_d[win]  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d        = S_IDLE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                state_d         = S_IDLE;
                done_d[owner_q] = 1'b1;
                rdata_en        = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ load path
    assign lane_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign lane_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    assign sext      = !mode_q[2];

    always_comb begin
        case (mode_q[1:0])
            M_BYTE:  load_val = {{24{sext & lane_byte[7]}}, lane_byte};
            M_HALF:  load_val = {{16{sext & lane_half[15]}}, lane_half};
            default: load_val = mem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (rdata_en && !owner_q) rdata0_q <= load_val;
            if (rdata_en &&  owner_q) rdata1_q <= load_val;
        end
    end

    // NOTE: the latched request is plain datapath, loaded on every accept and
    // only read while a transaction is live, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q <= win;
            we_q    <= sel_we;
            mode_q  <= sel_mode;
            addr_q  <= sel_addr[ADDR_W+1:0];
            wdata_q <= sel_wdata;
        end
    end

    // ------------------------------------------------------------ memory side
    assign mem_en_o   = (state_q == S_ISSUE);
    assign mem_we_o   = mem_en_o && we_q;
    assign mem_addr_o = addr_q[ADDR_W+1:2];

    always_comb begin
        mem_be_o    = 4'b0000;
        mem_wdata_o = wdata_q;
        if (mem_we_o) begin
            case (mode_q[1:0])
                M_WORD:  mem_be_o = 4'b1111;
                M_BYTE:  mem_be_o = 4'b0001 << addr_q[1:0];
                M_HALF:  mem_be_o = addr_q[1] ? 4'b1100 : 4'b0011;
                default: mem_be_o = 4'b0000;
            endcase
        end
        // Replicate narrow data across all lanes; the enables pick the lane.
        case (mode_q[1:0])
            M_BYTE:  mem_wdata_o = {4{wdata_q[7:0]}};
            M_HALF:  mem_wdata_o = {2{wdata_q[15:0]}};
            default: mem_wdata_o = wdata_q;
        endcase
    end

    assign p0_done_o  = done_q[0];
    assign p1_done_o  = done_q[1];
    assign p0_err_o   = err_q[0];
    assign p1_err_o   = err_q[1];
    assign p0_rdata_o = rdata0_q;
    assign p1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed and random traffic on both ports, with a
// byte-addressed reference memory and per-port expected-completion queues.
`timescale 1ns/1ps
module tb_dm_arbiter;

    localparam int ADDR_W = 10;
    localparam int WORDS  = 1 << ADDR_W;

    typedef struct {
        int          cyc;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
    } done_t;

    typedef struct {
        int              cyc;
        bit              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]      be;
        logic [31:0]     wdata;
    } memop_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req   [2];
    logic              wen   [2];
    logic [31:0]       addr  [2];
    logic [31:0]       wdat  [2];
    logic [2:0]        mode  [2];
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [1:0]        err;
    logic [31:0]       rdata [2];
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    done_t  dq0 [$];
    done_t  dq1 [$];
    memop_t mq  [$];
    int     gorder [$];
    int     m_last = 1;
    int     busy_until = 0;

    logic [7:0]  ref_mem [WORDS*4];
    logic [31:0] sram    [WORDS];
    bit          sram_init = 1'b0;

    dm_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .p0_req_i(req[0]), .p0_gnt_o(gnt[0]), .p0_we_i(wen[0]), .p0_addr_i(addr[0]),
        .p0_wdata_i(wdat[0]), .p0_mode_i(mode[0]), .p0_done_o(done[0]), .p0_err_o(err[0]),
        .p0_rdata_o(rdata[0]),
        .p1_req_i(req[1]), .p1_gnt_o(gnt[1]), .p1_we_i(wen[1]), .p1_addr_i(addr[1]),
        .p1_wdata_i(wdat[1]), .p1_mode_i(mode[1]), .p1_done_o(done[1]), .p1_err_o(err[1]),
        .p1_rdata_o(rdata[1]),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // SRAM macro: byte-enabled write, one-cycle read latency.
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int w = 0; w < WORDS; w++) sram[w] <= init_word(w);
            sram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion checks for one port against its expected queue.
    task automatic check_port(input int p);
        done_t e;
        bit    have;
        have = (p == 0) ? (dq0.size() > 0) : (dq1.size() > 0);
        if (have) e = (p == 0) ? dq0[0] : dq1[0];
        if (!done[p]) check($sformatf("p%0d err without done", p), 32'(err[p]), 32'h0);
        if (done[p]) begin
            if (!have) begin
                check($sformatf("p%0d done (none expected)", p), 32'(done[p]), 32'h0);
            end else begin
                if (p == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
                check($sformatf("p%0d done cycle", p), 32'(cyc), 32'(e.cyc));
                check($sformatf("p%0d err", p), 32'(err[p]), 32'(e.err));
                if (e.chk) check($sformatf("p%0d rdata", p), rdata[p], e.rdata);
            end
        end else if (have && cyc >= e.cyc) begin
            check($sformatf("p%0d done missing", p), 32'(done[p]), 32'h1);
            if (p == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
        end
    endtask

    // Monitor + reference model, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        int          p, n, base;
        logic [31:0] a, val, wd;
        logic [2:0]  m;
        logic [3:0]  be;
        logic [1:0]  rq, exp_g;
        bit          legal;
        memop_t      mo;
        done_t       de;
        if (reset) begin
            dq0.delete(); dq1.delete(); mq.delete(); gorder.delete();
            m_last = 1;
            busy_until = 0;
        end else begin
            check_port(0);
            check_port(1);

            if (mem_en) begin
                if (mq.size() == 0) begin
                    check("mem_en (no access expected)", 32'(mem_en), 32'h0);
                end else begin
                    mo = mq.pop_front();
                    check("mem cycle", 32'(cyc), 32'(mo.cyc));
                    check("mem_we", 32'(mem_we), 32'(mo.we));
                    check("mem_addr", 32'(mem_addr), 32'(mo.addr));
                    check("mem_be", 32'(mem_be), 32'(mo.be));
                    if (mo.we) check("mem_wdata", mem_wdata, mo.wdata);
                end
            end else begin
                check("idle mem_we/mem_be", {27'h0, mem_we, mem_be}, 32'h0);
                if (mq.size() > 0 && cyc >= mq[0].cyc) begin
                    check("mem_en missing", 32'(mem_en), 32'h1);
                    void'(mq.pop_front());
                end
            end

            rq = {req[1], req[0]};
            if (cyc < busy_until) exp_g = 2'b00;
            else if (rq == 2'b11) begin
`ifdef DM_FIXED_PRIO_EN
                exp_g = 2'b01;
`else
                exp_g = (m_last == 1) ? 2'b01 : 2'b10;
`endif
            end else exp_g = rq;
            check("grant", 32'(gnt), 32'(exp_g));

            p = (gnt[0] && req[0]) ? 0 : ((gnt[1] && req[1]) ? 1 : -1);
            if (p >= 0) begin
                gorder.push_back(p);
                m_last = p;
                a = addr[p];
                m = mode[p];
                case (m[1:0])
                    2'b00:   n = 4;
                    2'b01:   n = 1;
                    2'b10:   n = 2;
                    default: n = 0;
                endcase
                legal = (n != 0) && ((int'(a[1:0]) % n) == 0);
                de.chk = 1'b0;
                de.rdata = 32'h0;
                if (!legal) begin
                    de.cyc = cyc + 1;
                    de.err = 1'b1;
                end else begin
                    base = int'(a[ADDR_W+1:0]);
                    mo.cyc  = cyc + 1;
                    mo.we   = wen[p];
                    mo.addr = ADDR_W'(base / 4);
                    de.err  = 1'b0;
                    if (wen[p]) begin
                        be = 4'(((1 << n) - 1) << (base % 4));
                        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdat[p][8*(i % n) +: 8];
                        for (int i = 0; i < n; i++) ref_mem[base + i] = wdat[p][8*i +: 8];
                        mo.be    = be;
                        mo.wdata = wd;
                        de.cyc   = cyc + 2;
                    end else begin
                        val = 32'h0;
                        for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[base + i];
                        if (n < 4 && !m[2] && val[8*n-1])
                            for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
                        mo.be    = 4'b0000;
                        mo.wdata = 32'h0;
                        de.cyc   = cyc + 3;
                        de.chk   = 1'b1;
                        de.rdata = val;
                    end
                    mq.push_back(mo);
                end
                busy_until = de.cyc;
                if (p == 0) dq0.push_back(de); else dq1.push_back(de);
            end
        end
    end

    // Called at 1 ns after a rising edge; returns 1 ns after the edge that
    // follows the accept.
    task automatic issue(input int p, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] m);
        int n = 0;
        wen[p] = w; addr[p] = a; wdat[p] = d; mode[p] = m; req[p] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[p] && n < 200);
        if (!gnt[p]) check($sformatf("p%0d grant timeout", p), 32'(gnt[p]), 32'h1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((dq0.size() + dq1.size() + mq.size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(dq0.size() + dq1.size() + mq.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic rand_port(input int p, input int cnt);
        logic [31:0] a, d;
        logic [2:0]  m;
        bit          w;
        int          gap;
        for (int i = 0; i < cnt; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'h0000_003F;
            d = $urandom;
            m = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            issue(p, w, a, d, m);
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [4];
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; wen[p] = 1'b0; addr[p] = 32'h0; wdat[p] = 32'h0; mode[p] = 3'b000;
        end
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w)[8*b +: 8];

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset p0_done", 32'(done[0]), 32'h0);
        check("reset p1_done", 32'(done[1]), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset p0_rdata", rdata[0], 32'h0);
        check("reset p1_rdata", rdata[1], 32'h0);
        check("reset mem_en", 32'(mem_en), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Both ports requesting continuously straight out of reset
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'h20 + 32'(4*i), 32'h0, 3'b000); end
            begin for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'h40 + 32'(4*i), 32'h0, 3'b000); end
        join
        wait_drain();
`ifdef DM_FIXED_PRIO_EN
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`else
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif
        check("grant count", 32'(gorder.size()), 32'd8);
        for (int i = 0; i < 4 && i < gorder.size(); i++)
            check($sformatf("grant order %0d", i), 32'(gorder[i]), 32'(exp_order[i]));

        // sw 0x10: write on cycle 1, done on cycle 2
        issue(0, 1'b1, 32'h10, 32'h1234_5678, 3'b000);
        @(negedge clk);
        check("sw mem_en", 32'(mem_en), 32'h1);
        check("sw mem_we", 32'(mem_we), 32'h1);
        check("sw mem_addr", 32'(mem_addr), 32'h4);
        check("sw mem_be", 32'(mem_be), 32'hF);
        check("sw mem_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        check("sw p0_done", 32'(done[0]), 32'h1);
        check("sw p0_err", 32'(err[0]), 32'h0);
        @(posedge clk); #1;

        // sb 0x13, then lb / lbu of the same byte
        issue(0, 1'b1, 32'h13, 32'h0000_00AB, 3'b001);
        @(negedge clk);
        check("sb mem_be", 32'(mem_be), 32'h8);
        check("sb mem_wdata", mem_wdata, 32'hABAB_ABAB);
        wait_drain();
        issue(0, 1'b0, 32'h13, 32'h0, 3'b001);
        wait_drain();
        check("lb p0_rdata", rdata[0], 32'hFFFF_FFAB);
        issue(0, 1'b0, 32'h13, 32'h0, 3'b101);
        wait_drain();
        check("lbu p0_rdata", rdata[0], 32'h0000_00AB);

        // Half loads on port 1
        issue(0, 1'b1, 32'h10, 32'h8001_7FFF, 3'b000);
        wait_drain();
        issue(1, 1'b0, 32'h12, 32'h0, 3'b010);
        wait_drain();
        check("lh 0x12 p1_rdata", rdata[1], 32'hFFFF_8001);
        issue(1, 1'b0, 32'h10, 32'h0, 3'b010);
        wait_drain();
        check("lh 0x10 p1_rdata", rdata[1], 32'h0000_7FFF);
        issue(1, 1'b0, 32'h12, 32'h0, 3'b110);
        wait_drain();
        check("lhu 0x12 p1_rdata", rdata[1], 32'h0000_8001);

        // Illegal accesses: done+err on cycle 1, no memory access
        issue(0, 1'b1, 32'h12, 32'hDEAD_BEEF, 3'b000);
        @(negedge clk);
        check("misaligned sw done", 32'(done[0]), 32'h1);
        check("misaligned sw err", 32'(err[0]), 32'h1);
        check("misaligned sw mem_en", 32'(mem_en), 32'h0);
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h0, 32'h0, 3'b011);
        @(negedge clk);
        check("reserved mode done", 32'(done[0]), 32'h1);
        check("reserved mode err", 32'(err[0]), 32'h1);
        check("reserved mode mem_en", 32'(mem_en), 32'h0);
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h11, 32'h0, 3'b010);
        wait_drain();

        // Random traffic on both ports
        fork
            rand_port(0, 150);
            rand_port(1, 150);
        join
        wait_drain();

        // Reset during RDATA abandons the load; pending p1 gets the first grant
        wen[0] = 1'b0; addr[0] = 32'h20; mode[0] = 3'b000; req[0] = 1'b1;
        @(negedge clk);
        check("pre-reset p0_gnt", 32'(gnt[0]), 32'h1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wen[1] = 1'b0; addr[1] = 32'h24; mode[1] = 3'b000; req[1] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rdata-cycle p0_done", 32'(done[0]), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post-reset p0_done", 32'(done[0]), 32'h0);
        check("post-reset mem_en", 32'(mem_en), 32'h0);
        check("post-reset p1_gnt", 32'(gnt[1]), 32'h1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
